// File: rtl/filtered_ram_fill_sequencer.sv
// Fill sequencer: walks host RAM addresses for one projection line and writes
// the delayed FIR results into a swappable bank, one address per cycle.
module filtered_ram_fill_sequencer #(
   parameter int kSLength            = 9,
   parameter int kFilteredDataLength = 16,
   parameter int kLineSize           = 256,
   parameter int kFirDelay           = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  fill_kick,
   input  logic signed [kFilteredDataLength-1:0] fir_val,
   output logic        [kSLength-1:0]            hs_s_val,
   output logic                                  hs_addr_valid,
   output logic                                  wr_en,
   output logic        [kSLength-1:0]            wr_addr,
   output logic signed [kFilteredDataLength-1:0] wr_data,
   output logic                                  fill_done,
   output logic                                  kick_overrun
);

   localparam logic [1:0] idle_s  = 2'd0;
   localparam logic [1:0] issue_s = 2'd1;
   localparam logic [1:0] drain_s = 2'd2;

   localparam logic [kSLength-1:0] kLastAddr = kSLength'(kLineSize - 1);

   logic [1:0]          state_q, state_d;
   logic [kSLength-1:0] cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                ovr_q, ovr_d;
   logic                issue;

   // Delay line pairing each issued address with its FIR result.
   logic [kFirDelay-1:0]               pv_q, pv_d;
   logic [kFirDelay-1:0][kSLength-1:0] pa_q, pa_d;

   assign issue = (state_q == issue_s);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      ovr_d   = ovr_q;
      pv_d    = '0;
      pa_d    = '0;
      pv_d[0] = issue;
      pa_d[0] = issue ? cnt_q : '0;
      for (int i = 1; i < kFirDelay; i++) begin
         pv_d[i] = pv_q[i-1];
         pa_d[i] = pa_q[i-1];
      end
      unique case (state_q)
         idle_s: begin
            if (fill_kick) begin
               state_d = issue_s;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end
         issue_s: begin
            if (fill_kick) ovr_d = 1'b1;
            if (cnt_q == kLastAddr) state_d = drain_s;
            else cnt_d = cnt_q + 1'b1;
         end
         drain_s: begin
            if (fill_kick) ovr_d = 1'b1;
            if (pv_q[kFirDelay-1] && pa_q[kFirDelay-1] == kLastAddr) begin
               state_d = idle_s;
               done_d  = 1'b1;
            end
         end
         default: state_d = idle_s;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= idle_s;
         cnt_q   <= '0;
         done_q  <= 1'b1;
         ovr_q   <= 1'b0;
         pv_q    <= '0;
         pa_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         pv_q    <= pv_d;
         pa_q    <= pa_d;
      end
   end

   assign hs_s_val      = cnt_q;
   assign hs_addr_valid = issue;
   assign wr_en         = pv_q[kFirDelay-1];
   assign wr_addr       = pa_q[kFirDelay-1];
   assign wr_data       = fir_val;
   assign fill_done     = done_q;
   assign kick_overrun  = ovr_q;

endmodule
